// File: rtl/warp_pkg.sv
// Shared types and defaults for the warp engine.
package warp_pkg;

    localparam int ADDR_WIDTH                  = 32;
    localparam int ARB_MAX_OUTSTANDING_DEFAULT = 4;

    // Owner of a memory request; also the tag stored per outstanding read.
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LSU   = 1'b1
    } mem_req_id_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// Small FIFO of requester IDs, one entry per outstanding read.
// The head is readable combinationally so a response can be routed in the
// cycle it arrives. A push is accepted while full when a pop happens in the
// same cycle, because fullness is judged after the pop.
module arb_tag_fifo
    import warp_pkg::*;
#(
    parameter int DEPTH = ARB_MAX_OUTSTANDING_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  mem_req_id_e push_id,
    input  logic        pop,
    output mem_req_id_e head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mem_req_id_e      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // Accepted push/pop and status flags.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        head    = mem_q[rd_ptr_q];
    end

    // Tag storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_mem_arbiter.sv
// Shares the single memory port between the instruction-fetch path (FETCH)
// and the lane load/store path (LSU). Round-robin grant, held while the
// memory stalls; a tag FIFO routes in-order read responses to their owner.
// Build option: define WARP_ARB_FETCH_PRIORITY_EN for fixed FETCH priority.
//
// Handshake rule for every channel: a transfer happens in a cycle where
// valid and ready are both 1. Here *_req_ready is a same-cycle acceptance
// pulse derived from mem_req_ready, so requesters must hold valid and their
// payload stable until they see ready.
module warp_mem_arbiter
    import warp_pkg::*;
#(
    parameter int ADDR_WIDTH      = warp_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req_valid,
    output logic                  fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                  lsu_req_write,
    input  logic [DATA_WIDTH-1:0] lsu_req_data,
    output logic                  fetch_resp_valid,
    output logic [DATA_WIDTH-1:0] fetch_resp_data,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_write,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  busy,
    output logic                  err_unexpected_resp
);

    mem_req_id_e last_grant_q, last_grant_d;
    mem_req_id_e lock_id_q, lock_id_d;
    logic        lock_q, lock_d;
    logic        err_q, err_d;

    mem_req_id_e grant;
    mem_req_id_e fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        can_read;
    logic        fetch_ok;
    logic        lsu_ok;
    logic        handshake;

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .push_id (grant),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Grant selection, request mux, response routing and next state.
    always_comb begin
        fifo_pop = mem_resp_valid && !fifo_empty;
        // A response popping this cycle frees a slot for a read issued now.
        can_read = !fifo_full || fifo_pop;
        fetch_ok = fetch_req_valid && can_read;
        // Stores never occupy a tag, so they bypass the outstanding limit.
        lsu_ok   = lsu_req_valid && (lsu_req_write || can_read);

        grant         = REQ_FETCH;
        mem_req_valid = 1'b0;
        if (lock_q) begin
            grant         = lock_id_q;
            mem_req_valid = (lock_id_q == REQ_LSU) ? lsu_ok : fetch_ok;
        end else if (fetch_ok && lsu_ok) begin
`ifdef WARP_ARB_FETCH_PRIORITY_EN
            grant = REQ_FETCH;
`else
            grant = (last_grant_q == REQ_FETCH) ? REQ_LSU : REQ_FETCH;
`endif
            mem_req_valid = 1'b1;
        end else if (lsu_ok) begin
            grant         = REQ_LSU;
            mem_req_valid = 1'b1;
        end else if (fetch_ok) begin
            grant         = REQ_FETCH;
            mem_req_valid = 1'b1;
        end

        mem_req_addr  = (grant == REQ_LSU) ? lsu_req_addr : fetch_req_addr;
        mem_req_write = (grant == REQ_LSU) && lsu_req_write;
        mem_req_data  = (grant == REQ_LSU) ? lsu_req_data : '0;

        handshake       = mem_req_valid && mem_req_ready;
        fetch_req_ready = handshake && (grant == REQ_FETCH);
        lsu_req_ready   = handshake && (grant == REQ_LSU);
        fifo_push       = handshake && !mem_req_write;

        mem_resp_ready   = 1'b1;
        fetch_resp_valid = fifo_pop && (fifo_head == REQ_FETCH);
        lsu_resp_valid   = fifo_pop && (fifo_head == REQ_LSU);
        fetch_resp_data  = mem_resp_data;
        lsu_resp_data    = mem_resp_data;

        last_grant_d = handshake ? grant : last_grant_q;
        // Hold the grant across a stall so the presented address cannot change.
        lock_d       = mem_req_valid && !mem_req_ready;
        lock_id_d    = grant;
        err_d        = err_q || (mem_resp_valid && fifo_empty);

        busy                = fetch_req_valid || lsu_req_valid || lock_q || !fifo_empty;
        err_unexpected_resp = err_q;
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ_LSU;
            lock_q       <= 1'b0;
            lock_id_q    <= REQ_FETCH;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            err_q        <= err_d;
        end
    end

endmodule
